// File: rtl/len_counter_bank_pkg.sv
// Shared constants, types and helpers for the sound-chip length counter bank.
// Package name: snd_len_pkg.
package snd_len_pkg;

  localparam int SHORT_LEN_W   = 6;
  localparam int SHORT_MAX     = 64;
  localparam int DEFAULT_LEN_W = 8;

  // Counter value for the default build: one bit wider than the load field
  // so it can hold 2^LEN_W.
  typedef logic [DEFAULT_LEN_W:0] len_cnt_t;

  // Full-scale count of a channel: 64 for short channels, 2^len_w otherwise.
  function automatic int len_max(bit is_short, int len_w);
    return is_short ? SHORT_MAX : (1 << len_w);
  endfunction

endpackage

// File: rtl/len_counter_bank_if.sv
// Control/status bundle between the register block and the length counter bank.
// master drives the strobes and levels; slave (the bank) returns status.
interface len_counter_bank_if #(
  parameter int N_CH  = 4,
  parameter int LEN_W = 8
);

  logic                      len_tick;
  logic                      seq_skip_len;
  logic [N_CH-1:0]           len_we;
  logic [N_CH*LEN_W-1:0]     len_load;
  logic [N_CH-1:0]           trigger;
  logic [N_CH-1:0]           len_enable;
  logic [N_CH-1:0]           chan_enable;
  logic [N_CH*(LEN_W+1)-1:0] len_count;
  logic [N_CH-1:0]           expired;

  modport master (
    output len_tick, seq_skip_len, len_we, len_load, trigger, len_enable,
    input  chan_enable, len_count, expired
  );

  modport slave (
    input  len_tick, seq_skip_len, len_we, len_load, trigger, len_enable,
    output chan_enable, len_count, expired
  );

endinterface

// File: rtl/len_counter_chan.sv
// One length-counter channel: counter, channel-enable flag and expiry pulse.
// Optional enable-edge extra clock and reduced trigger reload under the
// LEN_EXTRA_CLOCK_EN macro.
module len_counter_chan
  import snd_len_pkg::*;
#(
  parameter bit IS_SHORT = 1'b1,
  parameter int LEN_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             len_tick,
  input  logic             seq_skip_len,
  input  logic             len_we,
  input  logic [LEN_W-1:0] len_load,
  input  logic             trigger,
  input  logic             len_enable,
  output logic [LEN_W:0]   count,
  output logic             chan_enable,
  output logic             expired
);

  localparam int             CW         = LEN_W + 1;
  localparam logic [LEN_W:0] MAX        = CW'(len_max(IS_SHORT, LEN_W));
  localparam logic [LEN_W:0] FIELD_MASK = IS_SHORT ? CW'((1 << SHORT_LEN_W) - 1)
                                                   : CW'((1 << LEN_W) - 1);

  logic [LEN_W:0] cnt_wr;
  logic [LEN_W:0] cnt_clk;
  logic [LEN_W:0] cnt_next;
  logic           en_next;
  logic           exp_next;
  logic           extra_clk;
  logic           reload_less;

`ifdef LEN_EXTRA_CLOCK_EN
  logic len_enable_q;

  // Registered copy of len_enable for 0->1 edge detection.
  always_ff @(posedge clk) begin
    if (rst) len_enable_q <= 1'b0;
    else     len_enable_q <= len_enable;
  end

  assign extra_clk   = len_enable & ~len_enable_q & seq_skip_len;
  assign reload_less = len_enable & seq_skip_len;
`else
  logic unused_seq_skip;
  assign unused_seq_skip = seq_skip_len;
  assign extra_clk       = 1'b0;
  assign reload_less     = 1'b0;
`endif

  // Next state: write, then optional extra clock, then trigger, then tick.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    en_next  = chan_enable;
    exp_next = 1'b0;
    cnt_wr   = len_we ? (MAX - ({1'b0, len_load} & FIELD_MASK)) : count;
    cnt_clk  = cnt_wr;

    if (extra_clk && cnt_wr != '0) begin
      cnt_clk = cnt_wr - CW'(1);
      if (cnt_clk == '0 && !trigger) begin
        en_next  = 1'b0;
        exp_next = 1'b1;
      end
    end

    cnt_next = cnt_clk;

    if (trigger) begin
      en_next = 1'b1;
      if (cnt_clk == '0) cnt_next = reload_less ? (MAX - CW'(1)) : MAX;
    end else if (len_tick && len_enable && cnt_clk != '0) begin
      cnt_next = cnt_clk - CW'(1);
      if (cnt_next == '0) begin
        en_next  = 1'b0;
        exp_next = 1'b1;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    if (rst) begin
      count       <= '0;
      chan_enable <= 1'b0;
      expired     <= 1'b0;
    end else begin
      count       <= cnt_next;
      chan_enable <= en_next;
      expired     <= exp_next;
    end
  end

endmodule

// File: rtl/len_counter_bank.sv
// Multi-channel length counter bank for the sound chip.
// Optional macro: LEN_EXTRA_CLOCK_EN (enable-edge extra clock, reduced reload).
module len_counter_bank #(
  parameter int              N_CH       = 4,
  parameter int              LEN_W      = 8,
  parameter logic [N_CH-1:0] SHORT_MASK = 4'b1011
) (
  input  logic               clk,
  input  logic               rst,
  len_counter_bank_if.slave  bus
);

  logic [N_CH-1:0][LEN_W:0] count_arr;
  logic [N_CH-1:0]          en_arr;
  logic [N_CH-1:0]          exp_arr;

  // One independent counter per channel, slicing the flattened buses.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    len_counter_chan #(
      .IS_SHORT (SHORT_MASK[i]),
      .LEN_W    (LEN_W)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .len_tick     (bus.len_tick),
      .seq_skip_len (bus.seq_skip_len),
      .len_we       (bus.len_we[i]),
      .len_load     (bus.len_load[i*LEN_W +: LEN_W]),
      .trigger      (bus.trigger[i]),
      .len_enable   (bus.len_enable[i]),
      .count        (count_arr[i]),
      .chan_enable  (en_arr[i]),
      .expired      (exp_arr[i])
    );
  end

  assign bus.len_count   = count_arr;
  assign bus.chan_enable = en_arr;
  assign bus.expired     = exp_arr;

endmodule

// File: tb/tb_len_counter_bank.sv
// Self-checking bench for len_counter_bank: a directed vector table plus
// hand-written multi-cycle sequences.
module tb_len_counter_bank;
  import snd_len_pkg::*;

  localparam int N_CH  = 4;
  localparam int LEN_W = 8;
  localparam int CW    = LEN_W + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  len_counter_bank_if #(.N_CH(N_CH), .LEN_W(LEN_W)) bus ();

  len_counter_bank #(
    .N_CH       (N_CH),
    .LEN_W      (LEN_W),
    .SHORT_MASK (4'b1011)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int ch;
    bit rst;
    bit we;
    int load;
    bit trig;
    bit len_en;
    bit tick;
    int e_cnt;
    bit e_en;
    bit e_exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int ch, bit r, bit we, int load, bit trig,
                              bit len_en, bit tick, int e_cnt, bit e_en, bit e_exp);
    vec_t v;
    v.ch = ch; v.rst = r; v.we = we; v.load = load; v.trig = trig;
    v.len_en = len_en; v.tick = tick; v.e_cnt = e_cnt; v.e_en = e_en; v.e_exp = e_exp;
    return v;
  endfunction

  function automatic int cnt_of(int ch);
    len_cnt_t c;
    c = bus.len_count[ch*CW +: CW];
    return int'(c);
  endfunction

  task automatic clear_inputs();
    rst              = 1'b0;
    bus.len_tick     = 1'b0;
    bus.seq_skip_len = 1'b0;
    bus.len_we       = '0;
    bus.len_load     = '0;
    bus.trigger      = '0;
    bus.len_enable   = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write_len(int ch, int load);
    logic [LEN_W-1:0] l;
    clear_inputs();
    l = LEN_W'(load);
    bus.len_we[ch] = 1'b1;
    bus.len_load[ch*LEN_W +: LEN_W] = l;
    cyc();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    logic [LEN_W-1:0] l;

    // ch, rst, we, load, trig, len_en, tick, e_cnt, e_en, e_exp
    vecs.push_back(mk(0, 1, 0,  0, 0, 0, 0,  0, 0, 0)); // reset
    vecs.push_back(mk(0, 0, 1, 60, 0, 0, 0,  4, 0, 0)); // 64-60
    vecs.push_back(mk(0, 0, 0,  0, 1, 1, 0,  4, 1, 0)); // trigger keeps nonzero
    vecs.push_back(mk(0, 0, 0,  0, 0, 1, 1,  3, 1, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0, 1, 1,  2, 1, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0, 1, 1,  1, 1, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0, 1, 1,  0, 0, 1)); // expiry
    vecs.push_back(mk(0, 0, 0,  0, 0, 1, 1,  0, 0, 0)); // no wrap, one pulse
    vecs.push_back(mk(3, 0, 1, 63, 1, 0, 0,  1, 1, 0)); // write+trigger: no reload
    vecs.push_back(mk(3, 0, 1, 'hC5, 0, 0, 0, 59, 1, 0)); // low 6 bits only, enable kept
    vecs.push_back(mk(1, 0, 1, 63, 0, 0, 0,  1, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0, 1, 1, 1,  1, 1, 0)); // tick dropped by trigger
    vecs.push_back(mk(1, 0, 0,  0, 0, 1, 1,  0, 0, 1));
    vecs.push_back(mk(1, 0, 0,  0, 0, 1, 0,  0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      clear_inputs();
      rst                     = vecs[i].rst;
      bus.len_tick            = vecs[i].tick;
      bus.len_we[vecs[i].ch]  = vecs[i].we;
      bus.trigger[vecs[i].ch] = vecs[i].trig;
      bus.len_enable[vecs[i].ch] = vecs[i].len_en;
      l = LEN_W'(vecs[i].load);
      bus.len_load[vecs[i].ch*LEN_W +: LEN_W] = l;
      cyc();
      check($sformatf("vec%0d cnt", i), cnt_of(vecs[i].ch), vecs[i].e_cnt);
      check($sformatf("vec%0d en", i), int'(bus.chan_enable[vecs[i].ch]), int'(vecs[i].e_en));
      check($sformatf("vec%0d exp", i), int'(bus.expired[vecs[i].ch]), int'(vecs[i].e_exp));
    end

    // Long channel 2: trigger from zero reloads 256, expires on the 256th tick.
    clear_inputs();
    bus.trigger[2] = 1'b1;
    cyc();
    check("ch2 reload cnt", cnt_of(2), 256);
    check("ch2 reload en", int'(bus.chan_enable[2]), 1);
    clear_inputs();
    bus.len_enable[2] = 1'b1;
    bus.len_tick      = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 256; k++) begin
      cyc();
      if (bus.expired[2]) pulses++;
      if (k == 255) begin
        check("ch2 tick255 cnt", cnt_of(2), 1);
        check("ch2 tick255 en", int'(bus.chan_enable[2]), 1);
      end
    end
    check("ch2 tick256 cnt", cnt_of(2), 0);
    check("ch2 tick256 en", int'(bus.chan_enable[2]), 0);
    check("ch2 expired pulses", pulses, 1);
    cyc();
    check("ch2 after cnt", cnt_of(2), 0);
    check("ch2 after exp", int'(bus.expired[2]), 0);

    // Load 0 on a long channel gives the full 256.
    write_len(2, 0);
    check("ch2 load0 cnt", cnt_of(2), 256);
    check("ch2 load0 en", int'(bus.chan_enable[2]), 0);

    // Freeze: disabled length keeps the count and the channel enabled.
    write_len(2, 246);
    check("freeze load cnt", cnt_of(2), 10);
    clear_inputs();
    bus.trigger[2] = 1'b1;
    cyc();
    clear_inputs();
    bus.len_tick = 1'b1;
    for (int k = 0; k < 20; k++) cyc();
    check("freeze cnt", cnt_of(2), 10);
    check("freeze en", int'(bus.chan_enable[2]), 1);
    bus.len_enable[2] = 1'b1;
    for (int k = 0; k < 9; k++) cyc();
    check("unfreeze 9 cnt", cnt_of(2), 1);
    check("unfreeze 9 en", int'(bus.chan_enable[2]), 1);
    cyc();
    check("unfreeze 10 cnt", cnt_of(2), 0);
    check("unfreeze 10 en", int'(bus.chan_enable[2]), 0);
    check("unfreeze 10 exp", int'(bus.expired[2]), 1);

    // Reset mid-count clears everything; later ticks change nothing.
    write_len(0, 34);
    check("rst pre cnt", cnt_of(0), 30);
    clear_inputs();
    bus.trigger[0] = 1'b1;
    cyc();
    clear_inputs();
    rst = 1'b1;
    cyc();
    check("rst counts nonzero", int'(bus.len_count != '0), 0);
    check("rst chan_enable", int'(bus.chan_enable), 0);
    check("rst expired", int'(bus.expired), 0);
    clear_inputs();
    bus.len_enable = '1;
    bus.len_tick   = 1'b1;
    for (int k = 0; k < 3; k++) cyc();
    for (int c = 0; c < N_CH; c++) check($sformatf("post-rst ch%0d cnt", c), cnt_of(c), 0);
    check("post-rst chan_enable", int'(bus.chan_enable), 0);

`ifdef LEN_EXTRA_CLOCK_EN
    // Enable edge while the next step skips length clocks once.
    write_len(0, 59);
    clear_inputs();
    bus.trigger[0] = 1'b1;
    cyc();
    clear_inputs();
    cyc();
    check("xclk pre cnt", cnt_of(0), 5);
    bus.len_enable[0] = 1'b1;
    bus.seq_skip_len  = 1'b1;
    cyc();
    check("xclk cnt", cnt_of(0), 4);
    check("xclk en", int'(bus.chan_enable[0]), 1);
    clear_inputs();
    rst = 1'b1;
    cyc();
    clear_inputs();
    bus.trigger[0]    = 1'b1;
    bus.len_enable[0] = 1'b1;
    bus.seq_skip_len  = 1'b1;
    cyc();
    check("xclk reload cnt", cnt_of(0), 63);
    check("xclk reload en", int'(bus.chan_enable[0]), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/len_counter_bank.md
Name: len_counter_bank

Overview:
- Multi-channel length counter for the sound chip; successor to the single-channel 6-bit length counter.
- Runs entirely on the system clock. A 256 Hz frame-sequencer strobe enables the decrement; there is no derived clock.
- Holds one counter per channel. Width is set per channel: 6-bit for square/noise, 8-bit for wave.
- Gates each channel's output enable when its counter expires.
- Supports immediate length writes, trigger reload-from-zero and counter readback.

Parameters:
- N_CH, 4: number of channels.
- LEN_W, 8: width of the widest length field. Each counter is LEN_W+1 bits so it can hold the value 2^LEN_W.
- SHORT_MASK, 4'b1011: bit i set means channel i uses a 6-bit length (max 64); bit clear means it uses LEN_W (max 2^LEN_W).

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- len_tick, input, 1: one-cycle strobe from the frame sequencer on each length step (256 Hz).
- seq_skip_len, input, 1: high while the next sequencer step will not clock length. Used only by the optional feature.
- len_we, input, N_CH: length-register write strobe, one bit per channel.
- len_load, input, N_CH*LEN_W: length load value. Channel i occupies [i*LEN_W +: LEN_W]; short channels use the low 6 bits only.
- trigger, input, N_CH: one-cycle trigger strobe per channel.
- len_enable, input, N_CH: length-enable level per channel.
- chan_enable, output, N_CH: channel active.
- len_count, output, N_CH*(LEN_W+1): current counter values, for readback and debug.
- expired, output, N_CH: one-cycle pulse when a counter reaches 0 through decrement.

Behaviour:
- MAX_i is 64 for short channels and 2^LEN_W for long channels. The load field is the low 6 bits (short) or LEN_W bits (long).
- Reset: all counters 0, chan_enable 0, expired 0, internal len_enable history 0.
- len_we[i]: counter_i <= MAX_i - load_i on the next edge. chan_enable is unaffected. Example: load 0 gives MAX; load 63 on a short channel gives 1.
- trigger[i]: chan_enable_i <= 1. If counter_i == 0 (after any same-cycle len_we), counter_i <= MAX_i; otherwise the counter is kept.
- Tick decrement: applies when len_tick & len_enable[i] & counter_i != 0 & !trigger[i]. The counter decrements by 1. On the transition 1->0: chan_enable_i <= 0 and expired_i pulses the following cycle.
- A tick with counter_i == 0 does nothing; the counter never wraps.
- Priority within one cycle, per channel: rst, then len_we, then trigger, then tick. len_we and trigger together means load first, then the reload-if-zero check uses the new value. A tick coinciding with a trigger is dropped for that channel.
- Channels are fully independent. Outputs are registered with 1-cycle latency from any input event.
- chan_enable never goes low except through expiry or rst. Deasserting len_enable freezes the counter without disabling the channel.

Optional Feature:
- Macro: LEN_EXTRA_CLOCK_EN.
- Defined:
  - Extra clock: a 0->1 transition of len_enable[i] (detected against a registered copy) while seq_skip_len=1 and counter_i != 0 decrements counter_i once immediately. If that reaches 0 and trigger[i] is not set this cycle, chan_enable_i <= 0 and expired_i pulses.
  - Trigger reload: a trigger that reloads to MAX with len_enable[i]=1 and seq_skip_len=1 loads MAX_i-1 instead.
- Undefined: seq_skip_len is ignored and no enable-edge logic is synthesised.

Decomposition:
- Package snd_len_pkg:
  - SHORT_LEN_W=6 and SHORT_MAX=64.
  - Function len_max(is_short, LEN_W).
  - Typedef len_cnt_t (LEN_W+1 bits).
- Sub-module len_counter_chan (parameters IS_SHORT, LEN_W): one channel's counter, enable flag, expired pulse and optional extra-clock logic.
- The bank instantiates N_CH channels in a generate loop and slices the flattened buses.

Test Plan:
- Short ch0: len_we with load=60, trigger, len_enable=1, 4 ticks -> counter 4,3,2,1,0; chan_enable falls after the 4th tick; expired pulses once; a 5th tick leaves the counter at 0.
- Long ch2: trigger with counter 0, no write -> counter=256, chan_enable=1. 256 ticks with enable -> expires exactly on the 256th.
- Freeze: counter=10, len_enable=0, 20 ticks -> counter stays 10, chan_enable stays 1. Re-enable and 10 ticks -> expires.
- Collisions:
  - ch1 counter=1: trigger and tick in the same cycle -> counter stays 1, chan_enable=1.
  - ch3: len_we with load=63 and trigger in the same cycle -> counter=1, no reload to 64.
- Reset mid-count: counter=30 with rst high for one cycle -> all counters 0, chan_enable 0. Ticks afterwards produce no change.
- With LEN_EXTRA_CLOCK_EN, ch0:
  - counter=5, seq_skip_len=1, len_enable 0->1 -> counter=4 with no tick.
  - counter=0, trigger with len_enable=1 and seq_skip_len=1 -> counter=63.
